// File: rtl/clock_scan_display.sv
// Six-digit multiplexed common-anode 7-segment driver for the clock time digits.
// Snapshots the digits per scan frame, scans one digit per slot, and blinks the field being set.
module clock_scan_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] secL,
    input  logic [3:0] secH,
    input  logic [3:0] minL,
    input  logic [3:0] minH,
    input  logic [3:0] hourL,
    input  logic [3:0] hourH,
    input  logic       blink_en,
    input  logic [1:0] blink_sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0]   div_cnt_reg;
    logic [2:0]         idx_reg;
    logic [2:0]         idx_next;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;
    logic               blink_phase_next;
    logic [3:0]         digit_in   [6];
    logic [3:0]         digit_reg  [6];
    logic [3:0]         digit_next [6];
    logic               tick;
    logic               frame_start;
    logic               blink_wrap;
    logic               suppress;
    logic [1:0]         field_next;
    logic [3:0]         shown_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] pattern;
        case (d)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    assign tick        = (div_cnt_reg == DIV_LAST);
    assign idx_next    = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    assign frame_start = tick && (idx_reg == 3'd5);

    assign digit_in[0] = secL;
    assign digit_in[1] = secH;
    assign digit_in[2] = minL;
    assign digit_in[3] = minH;
    assign digit_in[4] = hourL;
    assign digit_in[5] = hourH;

    // Bypass so the slot-0 digit shown on the frame-start edge is the freshly loaded one.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_snap
            assign digit_next[gi] = frame_start ? digit_in[gi] : digit_reg[gi];
        end
    endgenerate

    assign shown_digit      = digit_next[idx_next];
    assign blink_wrap       = (blink_cnt_reg == BLINK_LAST);
    assign blink_phase_next = (tick && blink_wrap) ? ~blink_phase_reg : blink_phase_reg;

    always_comb begin
        field_next = 2'd3;
        if (idx_next < 3'd2) begin
            field_next = 2'd1;
        end else if (idx_next < 3'd4) begin
            field_next = 2'd2;
        end
    end

    // blink_sel = 0 never matches a field, so it never suppresses.
    assign suppress = blink_en && blink_phase_next && (blink_sel == field_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg     <= '0;
            idx_reg         <= 3'd5;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                digit_reg[i] <= 4'hF;
            end
            an  <= 6'h3F;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            for (int i = 0; i < 6; i++) begin
                digit_reg[i] <= digit_next[i];
            end
            if (tick) begin
                idx_reg         <= idx_next;
                blink_cnt_reg   <= blink_wrap ? '0 : blink_cnt_reg + BLINK_W'(1);
                blink_phase_reg <= blink_phase_next;
                if (suppress) begin
                    an  <= 6'h3F;
                    seg <= 7'h7F;
                    dp  <= 1'b1;
                end else begin
                    an  <= ~(6'd1 << idx_next);
                    seg <= decode(shown_digit);
                    dp  <= !((idx_next == 3'd2) || (idx_next == 3'd4));
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_scan_display.sv
// Bench for clock_scan_display: directed literal checks plus randomized stimulus
// compared every cycle against a tick-count based reference model.
module tb_clock_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dig [6];
    logic       blink_en = 1'b0;
    logic [1:0] blink_sel = 2'd0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles and ticks since reset release.
    int         cyc_m = 0;
    int         ticks_m = 0;
    int         idx_m = 5;
    logic [3:0] snap_m [6];
    logic [5:0] exp_an = 6'h3F;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;

    always #5 clk = ~clk;

    clock_scan_display #(
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .secL     (dig[0]),
        .secH     (dig[1]),
        .minL     (dig[2]),
        .minH     (dig[3]),
        .hourL    (dig[4]),
        .hourH    (dig[5]),
        .blink_en (blink_en),
        .blink_sel(blink_sel),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got {an,seg,dp}=%h required %h", name, $time, act, expv);
        end
    endtask

    // Segments lit (active-high gfedcba) per digit, inverted for the common-anode pins.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] lit;
        case (v)
            4'd0:    lit = 7'h3F;
            4'd1:    lit = 7'h06;
            4'd2:    lit = 7'h5B;
            4'd3:    lit = 7'h4F;
            4'd4:    lit = 7'h66;
            4'd5:    lit = 7'h6D;
            4'd6:    lit = 7'h7D;
            4'd7:    lit = 7'h07;
            4'd8:    lit = 7'h7F;
            4'd9:    lit = 7'h6F;
            default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

    initial begin
        int phase;
        for (int i = 0; i < 6; i++) snap_m[i] = 4'hF;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cyc_m   = 0;
                ticks_m = 0;
                idx_m   = 5;
                for (int i = 0; i < 6; i++) snap_m[i] = 4'hF;
                exp_an  = 6'h3F;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                cyc_m++;
                if (cyc_m % SCAN_DIV == 0) begin
                    idx_m = ticks_m % 6;
                    if (idx_m == 0) begin
                        for (int i = 0; i < 6; i++) snap_m[i] = dig[i];
                    end
                    ticks_m++;
                    phase = (ticks_m / BLINK_DIV) % 2;
                    if (blink_en && phase == 1 && int'(blink_sel) == idx_m / 2 + 1) begin
                        exp_an  = 6'h3F;
                        exp_seg = 7'h7F;
                        exp_dp  = 1'b1;
                    end else begin
                        for (int j = 0; j < 6; j++) exp_an[j] = (j != idx_m);
                        exp_seg = seg_of(snap_m[idx_m]);
                        exp_dp  = !(idx_m == 2 || idx_m == 4);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("scan", {an, seg, dp}, {exp_an, exp_seg, exp_dp});
        end
    end

    task automatic wait_slot(input int target);
        int n = 0;
        while (!(idx_m == target && ticks_m > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_slot timeout: idx %0d required %0d", idx_m, target);
        end
    endtask

    logic [5:0] an_tbl  [6];
    logic [6:0] seg_tbl [6];
    logic [5:0] blink_tbl [18];

    initial begin
        an_tbl  = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        seg_tbl = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        blink_tbl = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F,
                      6'h3E, 6'h3D, 6'h3F, 6'h3F, 6'h2F, 6'h1F,
                      6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        for (int i = 0; i < 6; i++) dig[i] = 4'(i + 1);

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        $display("reset released, digits 1..6");

        repeat (SCAN_DIV) @(posedge clk);
        #1 chk("first_tick", {an, seg, dp}, {6'h3E, 7'h79, 1'b1});
        for (int s = 1; s <= 6; s++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1 chk($sformatf("slot%0d", s % 6), {an, seg, dp},
                   {an_tbl[s % 6], seg_tbl[s % 6], !((s % 6) == 2 || (s % 6) == 4)});
        end

        repeat (2 * SCAN_DIV) @(posedge clk);
        @(negedge clk);
        dig[0] = 4'd7;
        $display("secL -> 7 during slot %0d", idx_m);
        repeat (4 * SCAN_DIV) @(posedge clk);
        #1 chk("secL_new_frame", {an, seg, dp}, {6'h3E, 7'h78, 1'b1});

        @(negedge clk);
        dig[5] = 4'hA;
        $display("hourH -> A");
        repeat (11 * SCAN_DIV) @(posedge clk);
        #1 chk("hourH_blank", {an, seg, dp}, {6'h1F, 7'h7F, 1'b1});
        @(negedge clk);
        dig[5] = 4'd6;

        wait_slot(3);
        #1 rst = 1'b1;
        #1 chk("async_reset", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        blink_en  = 1'b1;
        blink_sel = 2'd2;
        @(negedge clk);
        #1 rst = 1'b0;
        $display("reset pulse at slot 3, blink minutes enabled");
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1 chk("restart_not_yet", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        @(posedge clk);
        #1 chk("restart_slot0", {an, seg, dp}, {6'h3E, 7'h78, 1'b1});
        for (int n = 1; n < 18; n++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1 chk($sformatf("blink_tick%0d", n), {26'd0, an}, {26'd0, blink_tbl[n]});
        end

        @(negedge clk);
        blink_sel = 2'd0;
        $display("blink_sel -> 0");
        repeat (40 * SCAN_DIV) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                int k;
                k = $urandom_range(0, 5);
                dig[k] = 4'($urandom_range(0, 15));
                $display("t=%0t digit %0d -> %h", $time, k, dig[k]);
            end
            if ($urandom_range(0, 39) == 0) begin
                blink_en  = 1'($urandom_range(0, 1));
                blink_sel = 2'($urandom_range(0, 3));
                $display("t=%0t blink_en=%0b blink_sel=%0d", $time, blink_en, blink_sel);
            end
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                $display("t=%0t reset pulse", $time);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
